// File: rtl/mysystem_sdram_clk_pll_ctrl.sv
// Refclk-domain controller for the SDRAM/system clock PLL: drives the PLL reset and
// holds system reset until the synchronised lock indication has been stable long enough.
module mysystem_sdram_clk_pll_ctrl #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned CNT_W               = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked,
  input  logic             relock_req,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             pll_ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] loss_count,
  output logic [CNT_W-1:0] timeout_count
);

  localparam int unsigned MaxAB = (LOCK_TIMEOUT_CYCLES > LOCK_STABLE_CYCLES) ?
                                  LOCK_TIMEOUT_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MaxCycles = (MaxAB > RST_PULSE_CYCLES) ? MaxAB : RST_PULSE_CYCLES;
  localparam int unsigned CntW = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [CntW-1:0] PulseLast   = CntW'(RST_PULSE_CYCLES - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StPllReset  = 2'd0,
    StWaitLock  = 2'd1,
    StStabilize = 2'd2,
    StRun       = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       loss_d, timeout_d;
  logic                   locked_s;
  logic                   restart;
  logic                   loss_inc;
  logic                   timeout_inc;

  assign locked_s = sync_q[SYNC_STAGES-1];
  assign state    = state_q;

  always_comb begin
    state_d     = state_q;
    restart     = 1'b0;
    timeout_inc = 1'b0;
    // A loss in RUN is counted even when a relock request arrives on the same cycle.
    loss_inc    = (state_q == StRun) && !locked_s;
    if (relock_req) begin
      state_d = StPllReset;
      restart = 1'b1;
    end else begin
      unique case (state_q)
        StPllReset: begin
          if (cnt_q == PulseLast) state_d = StWaitLock;
        end
        StWaitLock: begin
          if (locked_s) begin
            state_d = StStabilize;
          end else if (cnt_q == TimeoutLast) begin
            state_d     = StPllReset;
            timeout_inc = 1'b1;
          end
        end
        StStabilize: begin
          if (!locked_s) begin
            state_d = StWaitLock;
          end else if (cnt_q == StableLast) begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (!locked_s) state_d = StPllReset;
        end
        default: state_d = StPllReset;
      endcase
    end

    // Counter restarts on every state entry; it is idle in RUN so it never wraps there.
    if (restart || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (state_q == StRun) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end

    loss_d    = (loss_inc && (loss_count != '1)) ? loss_count + CNT_W'(1) : loss_count;
    timeout_d = (timeout_inc && (timeout_count != '1)) ?
                timeout_count + CNT_W'(1) : timeout_count;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q       <= StPllReset;
      cnt_q         <= '0;
      sync_q        <= '0;
      pll_rst       <= 1'b1;
      sys_rst       <= 1'b1;
      pll_ready     <= 1'b0;
      loss_count    <= '0;
      timeout_count <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sync_q        <= {sync_q[SYNC_STAGES-2:0], locked};
      pll_rst       <= (state_d == StPllReset);
      sys_rst       <= (state_d != StRun);
      pll_ready     <= (state_d == StRun);
      loss_count    <= loss_d;
      timeout_count <= timeout_d;
    end
  end

endmodule

// File: tb/tb_mysystem_sdram_clk_pll_ctrl.sv
// Scoreboard bench for mysystem_sdram_clk_pll_ctrl: directed scenarios plus random
// stimulus, every cycle compared against a phase/time reference model.
module tb_mysystem_sdram_clk_pll_ctrl;

  localparam int RP = 4;
  localparam int ST = 8;
  localparam int TO = 32;
  localparam int SS = 2;
  localparam int CW = 8;
  localparam int SAT = (1 << CW) - 1;

  localparam int PH_RST  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_STAB = 2;
  localparam int PH_RUN  = 3;

  logic          refclk = 1'b0;
  logic          rst = 1'b1;
  logic          locked = 1'b0;
  logic          relock_req = 1'b0;
  logic          pll_rst;
  logic          sys_rst;
  logic          pll_ready;
  logic [1:0]    state;
  logic [CW-1:0] loss_count;
  logic [CW-1:0] timeout_count;

  int checks = 0;
  int errors = 0;
  int cycle = 0;

  mysystem_sdram_clk_pll_ctrl #(
    .RST_PULSE_CYCLES   (RP),
    .LOCK_STABLE_CYCLES (ST),
    .LOCK_TIMEOUT_CYCLES(TO),
    .SYNC_STAGES        (SS),
    .CNT_W              (CW)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .locked       (locked),
    .relock_req   (relock_req),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .pll_ready    (pll_ready),
    .state        (state),
    .loss_count   (loss_count),
    .timeout_count(timeout_count)
  );

  always #10 refclk = ~refclk;

  // Reference model: phase, time spent in phase, locked history, event totals.
  int phase = PH_RST;
  int t_in = 0;
  int m_loss = 0;
  int m_tout = 0;
  int lk_hist[$];
  logic [20:0] exp_q[$];

  function automatic void model_step(input bit r, input bit l, input bit q);
    int nxt;
    bit ls;
    bit again;
    if (r) begin
      phase = PH_RST;
      t_in = 0;
      m_loss = 0;
      m_tout = 0;
      lk_hist.delete();
      for (int i = 0; i < SS; i++) lk_hist.push_back(0);
      return;
    end
    ls = lk_hist[0] != 0;
    nxt = phase;
    again = 0;
    if (phase == PH_RUN && !ls && m_loss < SAT) m_loss++;
    if (q) begin
      nxt = PH_RST;
      again = 1;
    end else if (phase == PH_RST) begin
      if (t_in == RP - 1) nxt = PH_WAIT;
    end else if (phase == PH_WAIT) begin
      if (ls) nxt = PH_STAB;
      else if (t_in == TO - 1) begin
        nxt = PH_RST;
        if (m_tout < SAT) m_tout++;
      end
    end else if (phase == PH_STAB) begin
      if (!ls) nxt = PH_WAIT;
      else if (t_in == ST - 1) nxt = PH_RUN;
    end else begin
      if (!ls) nxt = PH_RST;
    end
    t_in = (again || nxt != phase) ? 0 : t_in + 1;
    phase = nxt;
    void'(lk_hist.pop_front());
    lk_hist.push_back(int'(l));
  endfunction

  function automatic logic [20:0] model_out();
    return {phase[1:0], phase == PH_RST, phase != PH_RUN, phase == PH_RUN,
            m_loss[CW-1:0], m_tout[CW-1:0]};
  endfunction

  // Drive one cycle of inputs, queue the expected post-edge outputs, return after the edge.
  task automatic cyc(input bit r, input bit l, input bit q);
    @(negedge refclk);
    rst = r;
    locked = l;
    relock_req = q;
    model_step(r, l, q);
    exp_q.push_back(model_out());
    @(posedge refclk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic run_until(input bit l, input int st, input int bound, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      cyc(0, l, 0);
      if (int'(state) == st) begin
        ok = 1;
        break;
      end
    end
    check(name, int'(ok), 1);
  endtask

  // Monitor: every clock the DUT presents a full output set; compare with the queue head.
  initial begin
    logic [20:0] got;
    logic [20:0] exp;
    forever begin
      @(posedge refclk);
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = {state, pll_rst, sys_rst, pll_ready, loss_count, timeout_count};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL scoreboard cycle %0d: got st=%0d pr=%b sr=%b rdy=%b loss=%0d tout=%0d expected st=%0d pr=%b sr=%b rdy=%b loss=%0d tout=%0d",
                   cycle, got[20:19], got[18], got[17], got[16], got[15:8], got[7:0],
                   exp[20:19], exp[18], exp[17], exp[16], exp[15:8], exp[7:0]);
        end
      end
    end
  end

  initial begin
    int n;
    bit seen;
    bit lk;

    // 1: reset, then permanent lock.
    repeat (3) cyc(1, 0, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 0);
      n++;
      if (!pll_rst) break;
    end
    check("pll_rst_pulse_len", n, RP);
    run_until(1, PH_STAB, 10, "reach_stabilize");
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 0);
      n++;
      if (state == 2'd3) break;
    end
    check("stabilize_to_run", n, ST);
    check("run_sys_rst", int'(sys_rst), 0);
    check("run_pll_ready", int'(pll_ready), 1);

    // 2: lock never arrives; three timeouts.
    cyc(1, 0, 0);
    n = 0;
    for (int i = 0; i < 3 * (RP + TO); i++) begin
      cyc(0, 0, 0);
      if (i < RP + TO && state == 2'd1) n++;
    end
    check("wait_lock_dwell", n, TO);
    check("timeout_count_3", int'(timeout_count), 3);
    check("after_timeout_state", int'(state), PH_RST);

    // 3: one-cycle lock glitch during STABILIZE.
    run_until(1, PH_STAB, 60, "reach_stabilize_2");
    repeat (3) cyc(0, 1, 0);
    cyc(0, 0, 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 0);
      if (state == 2'd1) seen = 1;
      if (seen && state == 2'd2) break;
    end
    check("glitch_to_wait_lock", int'(seen), 1);
    check("glitch_loss_unchanged", int'(loss_count), 0);
    check("glitch_tout_unchanged", int'(timeout_count), 3);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 0);
      n++;
      if (state == 2'd3) break;
    end
    check("requalify_len", n, ST);

    // 4a: lock loss in RUN.
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0);
      n++;
      if (sys_rst) break;
    end
    check("loss_latency", n, SS + 1);
    check("loss_pll_rst", int'(pll_rst), 1);
    check("loss_count_1", int'(loss_count), 1);

    // 5: relock request alone, then coincident with a lock loss.
    run_until(1, PH_RUN, 60, "reach_run_5a");
    cyc(0, 1, 1);
    check("relock_state", int'(state), PH_RST);
    check("relock_no_loss", int'(loss_count), 1);
    run_until(1, PH_RUN, 60, "reach_run_5b");
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    check("relock_loss_state", int'(state), PH_RST);
    check("relock_loss_count", int'(loss_count), 2);

    // 4b: drive the loss counter into saturation.
    for (int k = 0; k < 300; k++) begin
      run_until(1, PH_RUN, 60, "reach_run_sat");
      run_until(0, PH_RST, 10, "lose_lock_sat");
    end
    check("loss_saturated", int'(loss_count), SAT);

    // 6: rst mid-STABILIZE with both counters nonzero.
    repeat (RP + TO + 4) cyc(0, 0, 0);
    check("tout_nonzero", int'(timeout_count != 0), 1);
    run_until(1, PH_STAB, 60, "reach_stabilize_6");
    repeat (2) cyc(0, 1, 0);
    cyc(1, 1, 0);
    check("rst_state", int'(state), PH_RST);
    check("rst_pll_rst", int'(pll_rst), 1);
    check("rst_sys_rst", int'(sys_rst), 1);
    check("rst_pll_ready", int'(pll_ready), 0);
    check("rst_loss", int'(loss_count), 0);
    check("rst_tout", int'(timeout_count), 0);

    // Random phase: long lock holds with occasional flips, relocks and resets.
    lk = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) lk = ~lk;
      cyc(($urandom_range(0, 599) == 0), lk, ($urandom_range(0, 149) == 0));
    end

    @(negedge refclk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
